// File: rtl/sd_filter_ctrl.sv
// Sequencing controller for the sigma-delta filter cascade: sample-enable divider,
// 1-bit feedback, settle discard and decimated valid/ready output stream.
module sd_filter_ctrl #(
   parameter int DATA_W = 47,
   parameter int DIV_W  = 16,
   parameter int DEC_W  = 8,
   parameter int SET_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DEC_W-1:0]  cfg_dec,
   input  logic [SET_W-1:0]  cfg_settle,
   input  logic              clr_overrun,
   input  logic [DATA_W-1:0] filt_out,
   output logic              filt_enb,
   output logic              filt_feedback,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_e;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, tick_q, tick_d;
   logic [DEC_W-1:0]  dec_q, dec_cnt_q, dec_cnt_d;
   logic [SET_W-1:0]  settle_q, settle_cnt_q, settle_cnt_d;
   logic              fb_pend_q, cap_pend_q;
   logic              feedback_q, m_valid_q, overrun_q;
   logic [DATA_W-1:0] m_data_q;

   logic pulse, start, settle_done, capture;

   assign pulse       = (state_q != IDLE) && (tick_q == div_q);
   assign start       = (state_q == IDLE) && run;
   assign settle_done = (state_q == SETTLE) && pulse && (settle_cnt_q + SET_W'(1) == settle_q);
   assign capture     = (state_q == RUN) && pulse && (dec_cnt_q == dec_q);

   // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: each combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (run) state_d = (cfg_settle == '0) ? RUN : SETTLE;
         SETTLE:  if (!run) state_d = IDLE;
                  else if (settle_done) state_d = RUN;
         RUN:     if (!run) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      filt_enb = pulse;
      busy     = (state_q != IDLE);
   end

   // Tick counter keeps running across SETTLE->RUN so the enable period never glitches.
   always_comb begin
      tick_d       = tick_q;
      settle_cnt_d = settle_cnt_q;
      dec_cnt_d    = dec_cnt_q;
      if (start) begin
         tick_d       = '0;
         settle_cnt_d = '0;
         dec_cnt_d    = '0;
      end else if (state_q != IDLE) begin
         tick_d = pulse ? '0 : tick_q + DIV_W'(1);
         if (pulse && state_q == SETTLE) settle_cnt_d = settle_cnt_q + SET_W'(1);
         if (pulse && state_q == RUN)    dec_cnt_d = capture ? '0 : dec_cnt_q + DEC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q        <= '0;
         dec_q        <= '0;
         settle_q     <= '0;
         tick_q       <= '0;
         settle_cnt_q <= '0;
         dec_cnt_q    <= '0;
         fb_pend_q    <= 1'b0;
         cap_pend_q   <= 1'b0;
         feedback_q   <= 1'b0;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         if (start) begin
            div_q    <= cfg_div;
            dec_q    <= cfg_dec;
            settle_q <= cfg_settle;
         end
         tick_q       <= tick_d;
         settle_cnt_q <= settle_cnt_d;
         dec_cnt_q    <= dec_cnt_d;
         fb_pend_q    <= pulse;
         cap_pend_q   <= capture;

         // filt_out is valid the cycle after the enable pulse, hence the pending flags.
         if (fb_pend_q) feedback_q <= ~filt_out[DATA_W-1];

         if (cap_pend_q) begin
            m_data_q  <= filt_out;
            m_valid_q <= 1'b1;
         end else if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
         end

         if (cap_pend_q && m_valid_q && !m_ready) overrun_q <= 1'b1;
         else if (clr_overrun || start)           overrun_q <= 1'b0;
      end
   end

   assign filt_feedback = feedback_q;
   assign m_data        = m_data_q;
   assign m_valid       = m_valid_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_sd_filter_ctrl.sv
// Directed bench for sd_filter_ctrl: reset/idle, sequencing, feedback, backpressure,
// stop/restart and mid-run reset, all against hand-computed cycle expectations.
module tb_sd_filter_ctrl;

   localparam int DATA_W = 47;

   logic              clk = 1'b0;
   logic              reset, run, clr_overrun, m_ready;
   logic [15:0]       cfg_div, cfg_settle;
   logic [7:0]        cfg_dec;
   logic [DATA_W-1:0] filt_out, m_data;
   logic              filt_enb, filt_feedback, m_valid, busy, overrun;

   int checks = 0;
   int errors = 0;

   sd_filter_ctrl dut (
      .clk(clk), .reset(reset), .run(run), .cfg_div(cfg_div), .cfg_dec(cfg_dec),
      .cfg_settle(cfg_settle), .clr_overrun(clr_overrun), .filt_out(filt_out),
      .filt_enb(filt_enb), .filt_feedback(filt_feedback), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chkd(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk1({tag, "_enb"}, filt_enb, 1'b0);
      chk1({tag, "_fb"}, filt_feedback, 1'b0);
      chk1({tag, "_valid"}, m_valid, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_ovr"}, overrun, 1'b0);
      chkd({tag, "_data"}, m_data, '0);
   endtask

   function automatic logic [DATA_W-1:0] val(input int c);
      return DATA_W'(c * 1000 + 7);
   endfunction

   initial begin
      reset = 1'b1; run = 1'b0; clr_overrun = 1'b0; m_ready = 1'b0;
      cfg_div = '0; cfg_dec = '0; cfg_settle = '0; filt_out = '0;

      // Reset and idle
      repeat (3) step();
      check_idle("reset");
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         chk1("idle_enb", filt_enb, 1'b0);
         chk1("idle_busy", busy, 1'b0);
         chk1("idle_valid", m_valid, 1'b0);
      end

      // Sequencing: div=3 settle=2 dec=1; cfg change mid-run must be ignored
      cfg_div = 16'd3; cfg_settle = 16'd2; cfg_dec = 8'd1; m_ready = 1'b1; run = 1'b1;
      filt_out = val(0);
      for (int c = 1; c <= 27; c++) begin
         step();
         filt_out = val(c);
         if (c == 10) cfg_div = 16'd0;
         chk1("seq_enb", filt_enb, (c % 4 == 0));
         chk1("seq_valid", m_valid, (c == 18 || c == 26));
         chk1("seq_busy", busy, 1'b1);
         chk1("seq_fb", filt_feedback, (c >= 6));
         if (c == 18) chkd("seq_data18", m_data, val(17));
         if (c == 26) chkd("seq_data26", m_data, val(25));
      end
      reset = 1'b1; run = 1'b0;
      step();
      reset = 1'b0;
      check_idle("seq_rst");

      // Feedback: div=0 settle=0, filt_out alternates -5/+5
      cfg_div = 16'd0; cfg_settle = 16'd0; cfg_dec = 8'd0; m_ready = 1'b1; run = 1'b1;
      filt_out = 47'sd5;
      for (int c = 1; c <= 10; c++) begin
         step();
         filt_out = (c % 2 == 1) ? -47'sd5 : 47'sd5;
         chk1("fb_enb", filt_enb, 1'b1);
         if (c == 2) chk1("fb_init", filt_feedback, 1'b0);
         if (c >= 3) begin
            chk1("fb_bit", filt_feedback, (c % 2 == 1));
            chk1("fb_valid", m_valid, 1'b1);
            chkd("fb_data", m_data, (c % 2 == 1) ? 47'sd5 : -47'sd5);
         end
      end
      reset = 1'b1; run = 1'b0;
      step();
      reset = 1'b0;
      check_idle("fb_rst");

      // Backpressure: div=0 dec=3, captures at pulses 4,8,12,...
      cfg_div = 16'd0; cfg_settle = 16'd0; cfg_dec = 8'd3; m_ready = 1'b0; run = 1'b1;
      filt_out = val(0);
      for (int c = 1; c <= 22; c++) begin
         step();
         filt_out = val(c);
         case (c)
            5:  chk1("bp_valid5", m_valid, 1'b0);
            6:  begin
                   chk1("bp_valid6", m_valid, 1'b1);
                   chkd("bp_data6", m_data, val(5));
                   chk1("bp_ovr6", overrun, 1'b0);
                end
            9:  begin
                   chkd("bp_hold9", m_data, val(5));
                   chk1("bp_ovr9", overrun, 1'b0);
                end
            10: begin
                   chk1("bp_ovr10", overrun, 1'b1);
                   chkd("bp_data10", m_data, val(9));
                   chk1("bp_valid10", m_valid, 1'b1);
                end
            11: clr_overrun = 1'b1;
            12: begin
                   chk1("bp_clr12", overrun, 1'b0);
                   clr_overrun = 1'b0;
                end
            13: m_ready = 1'b1;
            14: begin
                   chk1("bp_coinc_valid", m_valid, 1'b1);
                   chk1("bp_coinc_ovr", overrun, 1'b0);
                   chkd("bp_coinc_data", m_data, val(13));
                end
            15: begin
                   chk1("bp_xfer15", m_valid, 1'b0);
                   m_ready = 1'b0;
                end
            18: begin
                   chk1("bp_valid18", m_valid, 1'b1);
                   chkd("bp_data18", m_data, val(17));
                end
            21: begin
                   chk1("bp_ovr21", overrun, 1'b0);
                   clr_overrun = 1'b1;
                end
            22: begin
                   chk1("bp_set_beats_clr", overrun, 1'b1);
                   chkd("bp_data22", m_data, val(21));
                   clr_overrun = 1'b0;
                   run = 1'b0;
                end
            default: ;
         endcase
      end

      // Stop with a pending sample, then restart with div=1
      step();
      filt_out = val(99);
      chk1("stop_busy", busy, 1'b0);
      chk1("stop_enb", filt_enb, 1'b0);
      chk1("stop_valid", m_valid, 1'b1);
      chkd("stop_data", m_data, val(21));
      step();
      chk1("stop_enb2", filt_enb, 1'b0);
      chk1("stop_busy2", busy, 1'b0);
      chk1("stop_hold", m_valid, 1'b1);
      m_ready = 1'b1;
      step();
      chk1("stop_accept", m_valid, 1'b0);
      chk1("stop_ovr_sticky", overrun, 1'b1);
      cfg_div = 16'd1; cfg_dec = 8'd0; cfg_settle = 16'd0; run = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         step();
         if (n == 1) chk1("rs_ovr_clr", overrun, 1'b0);
         chk1("rs_busy", busy, 1'b1);
         chk1("rs_enb", filt_enb, (n % 2 == 0));
      end
      chk1("rs_valid6", m_valid, 1'b1);

      // Reset mid-run with a sample pending
      reset = 1'b1; run = 1'b0; m_ready = 1'b0;
      step();
      reset = 1'b0;
      check_idle("mid_rst");
      step();
      chk1("mid_rst_idle_busy", busy, 1'b0);
      chk1("mid_rst_idle_enb", filt_enb, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
